// File: rtl/jbi_ncrd_id_alloc_pkg.sv
// Shared jbi_mout NCRD constants plus the ID demux used by the allocator and the timeout tracker.
package jbi_ncrd_id_alloc_pkg;

    localparam int JBI_NCRD_IDS   = 16;
    localparam int JBI_NCRD_ID_W  = 4;
    localparam int JBI_NCRD_CNT_W = 5;

    function automatic logic [JBI_NCRD_IDS-1:0] jbi_demux_4to16(input logic [JBI_NCRD_ID_W-1:0] id);
        jbi_demux_4to16 = {{(JBI_NCRD_IDS-1){1'b0}}, 1'b1} << id;
    endfunction

    function automatic logic [JBI_NCRD_CNT_W-1:0] jbi_ncrd_popcnt(input logic [JBI_NCRD_IDS-1:0] v);
        jbi_ncrd_popcnt = '0;
        for (int i = 0; i < JBI_NCRD_IDS; i++)
            jbi_ncrd_popcnt = jbi_ncrd_popcnt + {{(JBI_NCRD_CNT_W-1){1'b0}}, v[i]};
    endfunction

endpackage

// File: rtl/jbi_ncrd_pick.sv
// Combinational free-ID finder. JBI_NCRD_RR_ALLOC_EN selects round-robin from i_start;
// otherwise the lowest-numbered free ID wins and i_start is ignored.
module jbi_ncrd_pick
    import jbi_ncrd_id_alloc_pkg::*;
(
    input  logic [JBI_NCRD_IDS-1:0]  i_free,
    input  logic [JBI_NCRD_ID_W-1:0] i_start,
    output logic                     o_found,
    output logic [JBI_NCRD_ID_W-1:0] o_idx
);

`ifdef JBI_NCRD_RR_ALLOC_EN
    logic [JBI_NCRD_ID_W-1:0] w_j;

    // Walk offsets high to low so the smallest offset from i_start is the last writer.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int i = JBI_NCRD_IDS-1; i >= 0; i--) begin
            w_j = i_start + i[JBI_NCRD_ID_W-1:0];
            if (i_free[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = ^i_start;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = JBI_NCRD_IDS-1; i >= 0; i--) begin
            if (i_free[i]) begin
                o_found = 1'b1;
                o_idx   = i[JBI_NCRD_ID_W-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/jbi_ncrd_id_alloc.sv
// NCRD JBus ID allocator: owns the busy vector, throttles to the CSR limit, handles quiesce.
// JBI_NCRD_RR_ALLOC_EN enables round-robin ID allocation (default: lowest free ID).
module jbi_ncrd_id_alloc
    import jbi_ncrd_id_alloc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic                      ncrd_sent,
    output logic [JBI_NCRD_ID_W-1:0]  ncrd_id,
    input  logic                      rtn_data_seen,
    input  logic [JBI_NCRD_ID_W-1:0]  rtn_data_id,
    input  logic                      ncio_mout_nack_pop,
    input  logic [JBI_NCRD_ID_W-1:0]  nack_error_id,
    input  logic [JBI_NCRD_CNT_W-1:0] csr_ncrd_max,
    input  logic                      csr_quiesce,
    output logic                      ncrd_idle,
    output logic [JBI_NCRD_CNT_W-1:0] ncrd_outstanding,
    output logic                      err_unexp_rtn
);

    localparam logic [JBI_NCRD_CNT_W-1:0] MAX_CNT = JBI_NCRD_IDS[JBI_NCRD_CNT_W-1:0];

    logic [JBI_NCRD_IDS-1:0]   r_busy;
    logic [JBI_NCRD_CNT_W-1:0] r_cnt;
    logic                      r_ncrd_sent;
    logic [JBI_NCRD_ID_W-1:0]  r_ncrd_id;
    logic                      r_ncrd_idle;
    logic                      r_err_unexp;

    logic [JBI_NCRD_CNT_W-1:0] w_lim;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_found;
    logic [JBI_NCRD_ID_W-1:0]  w_gid;
    logic [JBI_NCRD_ID_W-1:0]  w_start;
    logic [JBI_NCRD_IDS-1:0]   w_grant_oh;
    logic [JBI_NCRD_IDS-1:0]   w_free_d;
    logic [JBI_NCRD_IDS-1:0]   w_free_n;
    logic [JBI_NCRD_IDS-1:0]   w_free_ok;
    logic                      w_free_bad;
    logic [JBI_NCRD_CNT_W-1:0] w_cnt_next;
    logic [JBI_NCRD_IDS-1:0]   w_busy_next;

`ifdef JBI_NCRD_RR_ALLOC_EN
    logic [JBI_NCRD_ID_W-1:0]  r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_l)
            r_ptr <= '0;
        else if (w_accept)
            r_ptr <= w_gid + 1'b1;
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    jbi_ncrd_pick u_pick (
        .i_free  (~r_busy),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_gid)
    );

    assign w_lim    = (csr_ncrd_max == '0 || csr_ncrd_max > MAX_CNT) ? MAX_CNT : csr_ncrd_max;
    assign w_ready  = !csr_quiesce && (r_cnt < w_lim) && (r_busy != '1);
    assign w_accept = req_valid && w_ready && w_found;

    // A data return and a NACK for the same ID collapse to one free via the OR.
    assign w_free_d    = rtn_data_seen      ? jbi_demux_4to16(rtn_data_id)   : '0;
    assign w_free_n    = ncio_mout_nack_pop ? jbi_demux_4to16(nack_error_id) : '0;
    assign w_free_ok   = (w_free_d | w_free_n) & r_busy;
    assign w_free_bad  = |((w_free_d | w_free_n) & ~r_busy);
    assign w_grant_oh  = w_accept ? jbi_demux_4to16(w_gid) : '0;
    assign w_busy_next = (r_busy & ~w_free_ok) | w_grant_oh;
    assign w_cnt_next  = r_cnt + {{(JBI_NCRD_CNT_W-1){1'b0}}, w_accept} - jbi_ncrd_popcnt(w_free_ok);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_busy      <= '0;
            r_cnt       <= '0;
            r_ncrd_sent <= 1'b0;
            r_ncrd_id   <= '0;
            r_ncrd_idle <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            r_busy      <= w_busy_next;
            r_cnt       <= w_cnt_next;
            r_ncrd_sent <= w_accept;
            if (w_accept)
                r_ncrd_id <= w_gid;
            r_ncrd_idle <= csr_quiesce && (w_cnt_next == '0);
            r_err_unexp <= w_free_bad;
        end
    end

    assign req_ready        = w_ready;
    assign ncrd_sent        = r_ncrd_sent;
    assign ncrd_id          = r_ncrd_id;
    assign ncrd_idle        = r_ncrd_idle;
    assign ncrd_outstanding = r_cnt;
    assign err_unexp_rtn    = r_err_unexp;

endmodule

// File: tb/tb_jbi_ncrd_id_alloc.sv
// Directed-vector bench for jbi_ncrd_id_alloc; expectations follow JBI_NCRD_RR_ALLOC_EN.
module tb_jbi_ncrd_id_alloc;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       ncrd_sent;
    logic [3:0] ncrd_id;
    logic       rtn_data_seen = 1'b0;
    logic [3:0] rtn_data_id = '0;
    logic       ncio_mout_nack_pop = 1'b0;
    logic [3:0] nack_error_id = '0;
    logic [4:0] csr_ncrd_max = '0;
    logic       csr_quiesce = 1'b0;
    logic       ncrd_idle;
    logic [4:0] ncrd_outstanding;
    logic       err_unexp_rtn;

    int n_vec = 0;
    int n_err = 0;

`ifdef JBI_NCRD_RR_ALLOC_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    jbi_ncrd_id_alloc dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .ncrd_sent          (ncrd_sent),
        .ncrd_id            (ncrd_id),
        .rtn_data_seen      (rtn_data_seen),
        .rtn_data_id        (rtn_data_id),
        .ncio_mout_nack_pop (ncio_mout_nack_pop),
        .nack_error_id      (nack_error_id),
        .csr_ncrd_max       (csr_ncrd_max),
        .csr_quiesce        (csr_quiesce),
        .ncrd_idle          (ncrd_idle),
        .ncrd_outstanding   (ncrd_outstanding),
        .err_unexp_rtn      (err_unexp_rtn)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sent", ncrd_sent, 0);
        chk("rst_id", ncrd_id, 0);
        chk("rst_cnt", ncrd_outstanding, 0);
        chk("rst_idle", ncrd_idle, 0);
        chk("rst_err", err_unexp_rtn, 0);
        chk("rst_ready", req_ready, 1);
        rst_l = 1'b1;

        // Fill all 16 IDs back to back with the limit defaulted to 16
        req_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("fill_sent", ncrd_sent, 1);
            chk("fill_id", ncrd_id, k);
            chk("fill_cnt", ncrd_outstanding, k + 1);
        end
        chk("full_ready", req_ready, 0);
        tick();
        chk("full_sent", ncrd_sent, 0);
        chk("full_cnt", ncrd_outstanding, 16);
        req_valid = 1'b0;

        // Limit of 3, free ID 1, next grant depends on allocation mode
        do_reset();
        csr_ncrd_max = 5'd3;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lim_id", ncrd_id, k);
        end
        chk("lim_ready", req_ready, 0);
        tick();
        chk("lim_sent", ncrd_sent, 0);
        chk("lim_cnt", ncrd_outstanding, 3);
        rtn_data_seen = 1'b1; rtn_data_id = 4'd1;
        tick();
        rtn_data_seen = 1'b0;
        chk("lim_free_cnt", ncrd_outstanding, 2);
        chk("lim_free_ready", req_ready, 1);
        tick();
        chk("lim_regrant_sent", ncrd_sent, 1);
        chk("lim_regrant_id", ncrd_id, RR ? 3 : 1);
        chk("lim_regrant_cnt", ncrd_outstanding, 3);
        req_valid = 1'b0;
        csr_ncrd_max = 5'd0;

        // Same ID freed by data and NACK together, then accept+free overlap
        do_reset();
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        req_valid = 1'b0;
        chk("dup_pre_cnt", ncrd_outstanding, 6);
        rtn_data_seen = 1'b1; rtn_data_id = 4'd5;
        ncio_mout_nack_pop = 1'b1; nack_error_id = 4'd5;
        tick();
        rtn_data_seen = 1'b0; ncio_mout_nack_pop = 1'b0;
        chk("dup_cnt", ncrd_outstanding, 5);
        chk("dup_err", err_unexp_rtn, 0);
        req_valid = 1'b1;
        rtn_data_seen = 1'b1; rtn_data_id = 4'd0;
        tick();
        req_valid = 1'b0; rtn_data_seen = 1'b0;
        chk("ovl_sent", ncrd_sent, 1);
        chk("ovl_id", ncrd_id, RR ? 6 : 5);
        chk("ovl_cnt", ncrd_outstanding, 5);
        chk("ovl_err", err_unexp_rtn, 0);
        rtn_data_seen = 1'b1; rtn_data_id = 4'd1;
        ncio_mout_nack_pop = 1'b1; nack_error_id = 4'd2;
        tick();
        rtn_data_seen = 1'b0; ncio_mout_nack_pop = 1'b0;
        chk("two_free_cnt", ncrd_outstanding, 3);

        // Return for an ID that is not busy
        rtn_data_seen = 1'b1; rtn_data_id = 4'd9;
        tick();
        rtn_data_seen = 1'b0;
        chk("unexp_err", err_unexp_rtn, 1);
        chk("unexp_cnt", ncrd_outstanding, 3);
        tick();
        chk("unexp_err_clr", err_unexp_rtn, 0);
        chk("unexp_cnt_hold", ncrd_outstanding, 3);

        // Quiesce with 4 outstanding, drain them
        do_reset();
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        csr_quiesce = 1'b1;
        #1;
        chk("qsc_ready", req_ready, 0);
        tick();
        chk("qsc_sent", ncrd_sent, 0);
        chk("qsc_cnt", ncrd_outstanding, 4);
        chk("qsc_idle0", ncrd_idle, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                ncio_mout_nack_pop = 1'b1; nack_error_id = 4'(k);
            end else begin
                rtn_data_seen = 1'b1; rtn_data_id = 4'(k);
            end
            tick();
            rtn_data_seen = 1'b0; ncio_mout_nack_pop = 1'b0;
            chk("drain_cnt", ncrd_outstanding, 3 - k);
            chk("drain_idle", ncrd_idle, (k == 3) ? 1 : 0);
        end
        chk("drain_ready", req_ready, 0);
        req_valid = 1'b0;
        csr_quiesce = 1'b0;
        #1;
        chk("unqsc_ready", req_ready, 1);
        tick();
        chk("unqsc_idle", ncrd_idle, 0);

        // Reset with 7 outstanding
        do_reset();
        req_valid = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_cnt", ncrd_outstanding, 7);
        chk("mid_id", ncrd_id, 6);
        rst_l = 1'b0;
        tick();
        chk("mid_rst_sent", ncrd_sent, 0);
        chk("mid_rst_id", ncrd_id, 0);
        chk("mid_rst_cnt", ncrd_outstanding, 0);
        chk("mid_rst_idle", ncrd_idle, 0);
        chk("mid_rst_err", err_unexp_rtn, 0);
        chk("mid_rst_ready", req_ready, 1);
        csr_quiesce = 1'b1;
        #1;
        chk("mid_rst_ready_q", req_ready, 0);
        csr_quiesce = 1'b0;
        rst_l = 1'b1;
        tick();
        chk("post_rst_sent", ncrd_sent, 1);
        chk("post_rst_id", ncrd_id, 0);
        chk("post_rst_cnt", ncrd_outstanding, 1);
        req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
